seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
//  It shares one external combinational hex-to-7-segment decoder across all digits:
//   - presents one nibble per dwell slot on nib_out;
//   - samples the decoded pattern on seg_in;
//   - drives seg_out and the active-low anode lines an_n.

---
 rtl/seg_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// One external combinational hex decoder is shared across all digits; host
// writes are double-buffered and applied only at a frame boundary.
module seg_scan_ctrl #(
  parameter int unsigned NDIG      = 4,
  parameter int unsigned DWELL     = 50000,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_data,
  input  logic [NDIG-1:0]   blank_mask,
  output logic [3:0]        nib_out,
  input  logic [6:0]        seg_in,
  output logic [6:0]        seg_out,
  output logic [NDIG-1:0]   an_n,
  output logic              frame_tick
);

  localparam int unsigned CMAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned DW   = $clog2(NDIG);
  localparam int unsigned BW   = 4 * NDIG;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dig_q, dig_d;
  logic [6:0]      seg_lat_q, seg_lat_d;
  logic [BW-1:0]   active_q, active_d;
  logic [BW-1:0]   pend_buf_q, pend_buf_d;
  logic            pending_q, pending_d;
  logic            load_ready_q, load_ready_d;
  logic [NDIG-1:0] an_n_q, an_n_d;
  logic [6:0]      seg_out_q, seg_out_d;
  logic            frame_tick_q, frame_tick_d;
  logic            boundary;
  logic            accept;
  logic            lit;

  // Next-state for scan FSM, load buffer and registered pin outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dig_d        = dig_q;
    seg_lat_d    = seg_lat_q;
    active_d     = active_q;
    pend_buf_d   = pend_buf_q;
    pending_d    = pending_q;
    load_ready_d = load_ready_q;
    boundary     = 1'b0;
    accept       = load_valid && load_ready_q;

    case (state_q)
      BLANK: begin
        if (cnt_q == CW'(BLANK_CYC - 1)) begin
          seg_lat_d = seg_in;
          cnt_d     = '0;
          state_d   = SHOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHOW: begin
        if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d    = '0;
          state_d  = BLANK;
          boundary = (dig_q == DW'(NDIG - 1));
          dig_d    = boundary ? '0 : dig_q + DW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = BLANK;
    endcase

    // Pending data can only exist while load_ready is low, so an accept and
    // a buffer transfer never collide on the same edge.
    if (boundary && pending_q) begin
      active_d     = pend_buf_q;
      pending_d    = 1'b0;
      load_ready_d = 1'b1;
    end
    if (accept) begin
      pend_buf_d   = load_data;
      pending_d    = 1'b1;
      load_ready_d = 1'b0;
    end

    // Outputs are computed from the next state so they line up with it
    lit          = (state_d == SHOW) && !blank_mask[dig_d];
    an_n_d       = lit ? ~(NDIG'(1) << dig_d) : '1;
    seg_out_d    = lit ? seg_lat_d : 7'h7F;
    frame_tick_d = (state_d == SHOW) && (dig_d == DW'(NDIG - 1)) &&
                   (cnt_d == CW'(DWELL - 1));
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      dig_q        <= '0;
      seg_lat_q    <= 7'h7F;
      active_q     <= '0;
      pend_buf_q   <= '0;
      pending_q    <= 1'b0;
      load_ready_q <= 1'b1;
      an_n_q       <= '1;
      seg_out_q    <= 7'h7F;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      seg_lat_q    <= seg_lat_d;
      active_q     <= active_d;
      pend_buf_q   <= pend_buf_d;
      pending_q    <= pending_d;
      load_ready_q <= load_ready_d;
      an_n_q       <= an_n_d;
      seg_out_q    <= seg_out_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Decoder sees the displayed digit's nibble; it settles during BLANK
  assign nib_out    = active_q[{dig_q, 2'b00} +: 4];
  assign load_ready = load_ready_q;
  assign an_n       = an_n_q;
  assign seg_out    = seg_out_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIG=4, DWELL=4, BLANK_CYC=1.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = 16'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  nib_out;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  an_n;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  bit ld_out = 1'b0;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] exp_disp;
    int          l1_c;
    logic [15:0] l1_d;
    logic        l1_rdy;
    int          l2_c;
    logic [15:0] l2_d;
    logic        l2_rdy;
  } frame_t;

  frame_t tbl [6];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIG(4), .DWELL(4), .BLANK_CYC(1)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .blank_mask(blank_mask), .nib_out(nib_out),
    .seg_in(seg_in), .seg_out(seg_out), .an_n(an_n), .frame_tick(frame_tick)
  );

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'h40; 4'h1: dec = 7'h79; 4'h2: dec = 7'h24; 4'h3: dec = 7'h30;
      4'h4: dec = 7'h19; 4'h5: dec = 7'h12; 4'h6: dec = 7'h02; 4'h7: dec = 7'h78;
      4'h8: dec = 7'h00; 4'h9: dec = 7'h10; 4'hA: dec = 7'h08; 4'hB: dec = 7'h03;
      4'hC: dec = 7'h46; 4'hD: dec = 7'h21; 4'hE: dec = 7'h06; default: dec = 7'h0E;
    endcase
  endfunction

  assign seg_in = dec(nib_out);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // At most one anode low at any sampled instant
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!$onehot0(~an_n)) begin
        errors++;
        $display("FAIL an_onehot @%0t: got %b expected at most one low", $time, an_n);
      end
    end
  end

  task automatic offer(input logic [15:0] d, input logic rdy);
    chk("ready_at_offer", 16'(load_ready), 16'(rdy));
    load_valid = 1'b1;
    load_data  = d;
    ld_out     = 1'b1;
  endtask

  task automatic drop_offer();
    if (ld_out) begin
      chk("ready_after_offer", 16'(load_ready), 16'h0);
      load_valid = 1'b0;
      ld_out     = 1'b0;
    end
  endtask

  // One full 20-cycle frame, starting from the BLANK cycle of digit 0
  task automatic run_frame(input frame_t f);
    int d, p;
    logic [3:0] nib;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drop_offer();
      d   = c / 5;
      p   = c % 5;
      nib = f.exp_disp[d*4 +: 4];
      if (p == 0) begin
        chk("blank_an", 16'(an_n), 16'hF);
        chk("blank_seg", 16'(seg_out), 16'h7F);
        chk("blank_nib", 16'(nib_out), 16'(nib));
      end else begin
        exp_an  = f.mask[d] ? 4'hF : ~(4'b0001 << d);
        exp_seg = f.mask[d] ? 7'h7F : dec(nib);
        chk("show_an", 16'(an_n), 16'(exp_an));
        chk("show_seg", 16'(seg_out), 16'(exp_seg));
      end
      chk("frame_tick", 16'(frame_tick), 16'(c == 19));
      if (c == 0) blank_mask = f.mask;
      if (c == f.l1_c) offer(f.l1_d, f.l1_rdy);
      if (c == f.l2_c) offer(f.l2_d, f.l2_rdy);
    end
  endtask

  initial begin
    frame_t z;
    tbl[0] = '{4'h0, 16'h0000,  3, 16'h7E3A, 1'b1, 10, 16'h1234, 1'b0};
    tbl[1] = '{4'h0, 16'h7E3A,  2, 16'h1234, 1'b1, -1, 16'h0,    1'b0};
    tbl[2] = '{4'h0, 16'h1234, 19, 16'h5678, 1'b1, -1, 16'h0,    1'b0};
    tbl[3] = '{4'h0, 16'h1234, -1, 16'h0,    1'b0, -1, 16'h0,    1'b0};
    tbl[4] = '{4'h4, 16'h5678,  1, 16'h9ABC, 1'b1, -1, 16'h0,    1'b0};
    tbl[5] = '{4'h0, 16'h9ABC,  8, 16'hDEF0, 1'b1, -1, 16'h0,    1'b0};
    z      = '{4'h0, 16'h0000, -1, 16'h0,    1'b0, -1, 16'h0,    1'b0};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_an", 16'(an_n), 16'hF);
    chk("rst_seg", 16'(seg_out), 16'h7F);
    chk("rst_ready", 16'(load_ready), 16'h1);
    chk("rst_tick", 16'(frame_tick), 16'h0);
    chk("rst_nib", 16'(nib_out), 16'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // Frame now shows DEF0: mask toggle mid-dwell on digit 0
    @(negedge clk);
    chk("seq_blank_an", 16'(an_n), 16'hF);
    @(negedge clk);
    chk("seq_d0_an", 16'(an_n), 16'hE);
    chk("seq_d0_seg", 16'(seg_out), 16'h40);
    blank_mask = 4'b0001;
    @(negedge clk);
    chk("mask_on_an", 16'(an_n), 16'hF);
    chk("mask_on_seg", 16'(seg_out), 16'h7F);
    blank_mask = 4'b0000;
    @(negedge clk);
    chk("mask_off_an", 16'(an_n), 16'hE);
    chk("mask_off_seg", 16'(seg_out), 16'h40);
    @(negedge clk);
    @(negedge clk);
    chk("seq_d1_blank", 16'(an_n), 16'hF);
    @(negedge clk);
    chk("seq_d1_an", 16'(an_n), 16'hD);
    chk("seq_d1_seg", 16'(seg_out), 16'h0E);
    offer(16'h1111, 1'b1);
    @(negedge clk);
    drop_offer();

    // Asynchronous reset mid-SHOW with a load pending
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_an", 16'(an_n), 16'hF);
    chk("arst_seg", 16'(seg_out), 16'h7F);
    chk("arst_ready", 16'(load_ready), 16'h1);
    chk("arst_tick", 16'(frame_tick), 16'h0);
    chk("arst_nib", 16'(nib_out), 16'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_frame(z);
    run_frame(z);
    chk("post_rst_ready", 16'(load_ready), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout @%0t: got no finish expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
